fifo_word_packer: RTL and testbench
===================================

# fifo_word_packer

Downstream consumer stage for the generic synchronous FIFO. It pops DATAWIDTH-bit items from the FIFO's read side and packs RATIO consecutive items into one wide word. Each wide word is presented on a valid/ready output for the wide-bus stages of the PCA projection datapath. Packing and output are double-buffered, so the block pops FIFO items while a finished word waits for the consumer.

## Interface
- DATAWIDTH, 8: width of one FIFO item.
- RATIO, 4: items per output word; legal range 2..16.
- CNTWIDTH, 3: width of item counters; must hold the value RATIO.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  DATAWIDTH  FIFO head item; valid whenever fifo_empty=0
- fifo_read  out  1  pop request to FIFO; combinational
- out_data  out  DATAWIDTH*RATIO  packed word; lane 0 = bits [DATAWIDTH-1:0]
- out_count  out  CNTWIDTH  number of valid lanes in out_data
- out_valid  out  1  out_data/out_count valid
- out_ready  in  1  consumer accepts the word when out_valid=1 and out_ready=1
- flush  in  1  present only with PACK_FLUSH_EN; one-cycle pulse

## Operation
- Assembly register asm_reg with counter asm_cnt (0..RATIO). Output register holds out_data, out_count and out_valid.
- Pop: fifo_read = !fifo_empty && !reset && (asm_cnt<RATIO || xfer) && !flush_pend.
  - On the edge with fifo_read=1, fifo_dout is written into lane asm_cnt and asm_cnt increments.
  - Lanes fill in pop order; the first popped item lands in lane 0.
- Transfer: xfer = (asm_cnt==RATIO || flush_cond) && (!out_valid || out_ready).
  - On the xfer edge, asm_reg is copied to out_data and out_count=asm_cnt.
  - out_valid is set, then asm_cnt clears to 0, or to 1 if a pop occurs on the same edge (that item goes to lane 0).
- Unfilled lanes of out_data are always 0.
- Output handshake:
  - out_valid && out_ready && !xfer on an edge → out_valid=0.
  - out_valid && out_ready && xfer on an edge → new word loaded and out_valid stays 1.
  - out_ready while out_valid=0 is ignored.
  - out_data and out_count hold stable while out_valid && !out_ready.
- fifo_read never asserts while fifo_empty=1.
- Reset, async, at any time including mid-word:
  - asm_cnt=0, asm_reg=0, out_data=0, out_count=0, out_valid=0, flush_pend=0; fifo_read=0 while reset is high.
  - Partially packed items are discarded; the pops that fetched them are not undone.

## Timing
- Last item of a word is popped at edge N, giving asm_cnt=RATIO. Earliest xfer is edge N+1, so out_valid rises after edge N+1.
- Sustained throughput with the FIFO non-empty and out_ready=1: one word per RATIO cycles, with no bubble between words.
- Back-pressure: with the output occupied and asm_cnt==RATIO, popping stops until xfer.
- Steady-state storage is at most 2*RATIO items (one held word plus one assembled word).

## Configuration
- PACK_FLUSH_EN defined:
  - flush port exists; a flush pulse sets flush_pend.
  - While flush_pend=1, pops are blocked.
  - flush_cond = flush_pend && asm_cnt>0. The transfer emits a partial word with out_count=asm_cnt and zero-filled upper lanes, then clears flush_pend.
  - flush_pend with asm_cnt==0 clears on the next edge without emitting a word; empty words are never produced.
  - A flush pulse arriving while flush_pend=1 is absorbed.
- PACK_FLUSH_EN undefined: no flush port, flush_cond=0, and out_count equals RATIO on every valid word.

## Test plan
- Reset value: hold reset, pulse clk → out_valid=0, out_data=0, out_count=0, fifo_read=0.
- Basic pack: FIFO holds 0x11,0x22,0x33,0x44, out_ready=1 → one word 0x44332211, out_count=4, with out_valid rising the cycle after the 4th pop.
- Streaming: 12 items 0x01..0x0C, out_ready=1 → words 0x04030201, 0x08070605, 0x0C0B0A09, with no extra stall cycles between words.
- Back-pressure: 12 items, out_ready=0 → fifo_read stops after 8 pops and out_data holds 0x04030201. Raise out_ready → remaining words arrive in order with no loss or duplication.
- Reset mid-word: pop 0xAA,0xBB, assert reset, then push 0x01..0x04 → single output word 0x04030201.
- Flush (PACK_FLUSH_EN): pop 0x5A,0x6B, pulse flush → word 0x00006B5A with out_count=2. A second flush with asm_cnt=0 → no word emitted.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Packs RATIO consecutive FIFO items into one wide valid/ready word, double-buffered.
// Optional partial-word flush is enabled by defining PACK_FLUSH_EN.

module fifo_word_packer_lane #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] din,
    output logic [DATAWIDTH-1:0] out_lane
);
    logic [DATAWIDTH-1:0] asm_lane;

    // On a transfer the lane hands its item to the output and restarts empty,
    // unless a pop lands in it on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_lane <= '0;
            out_lane <= '0;
        end else if (load) begin
            out_lane <= asm_lane;
            asm_lane <= wr_en ? din : '0;
        end else if (wr_en) begin
            asm_lane <= din;
        end
    end
endmodule

module fifo_word_packer #(
    parameter int DATAWIDTH = 8,
    parameter int RATIO     = 4,
    parameter int CNTWIDTH  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fifo_empty,
    input  logic [DATAWIDTH-1:0]       fifo_dout,
    output logic                       fifo_read,
    output logic [DATAWIDTH*RATIO-1:0] out_data,
    output logic [CNTWIDTH-1:0]        out_count,
    output logic                       out_valid,
`ifdef PACK_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       out_ready
);
    localparam logic [CNTWIDTH-1:0] FULL = CNTWIDTH'(RATIO);

    logic [CNTWIDTH-1:0]                asm_cnt;
    logic [RATIO-1:0][DATAWIDTH-1:0]    out_lanes;
    logic                               flush_pend;
    logic                               flush_cond;
    logic                               xfer;
    logic                               pop;

`ifdef PACK_FLUSH_EN
    assign flush_cond = flush_pend && (asm_cnt != '0);
`else
    assign flush_pend = 1'b0;
    assign flush_cond = 1'b0;
`endif

    assign xfer      = ((asm_cnt == FULL) || flush_cond) && (!out_valid || out_ready);
    assign pop       = !fifo_empty && !reset && ((asm_cnt < FULL) || xfer) && !flush_pend;
    assign fifo_read = pop;
    assign out_data  = out_lanes;

    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        logic wr_en;
        // A pop coinciding with a transfer always starts the next word in lane 0.
        assign wr_en = pop && (xfer ? (i == 0) : (asm_cnt == CNTWIDTH'(i)));
        fifo_word_packer_lane #(.DATAWIDTH(DATAWIDTH)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_en),
            .load     (xfer),
            .din      (fifo_dout),
            .out_lane (out_lanes[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_cnt   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_count <= asm_cnt;
            out_valid <= 1'b1;
            asm_cnt   <= pop ? CNTWIDTH'(1) : '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (pop) asm_cnt <= asm_cnt + CNTWIDTH'(1);
        end
    end

`ifdef PACK_FLUSH_EN
    // A pending flush retires once its word goes out, or at once if nothing is assembled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_pend <= 1'b0;
        end else if (flush_pend) begin
            if (xfer || (asm_cnt == '0)) flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer; flush scenario runs when PACK_FLUSH_EN is defined.

module tb_fifo_word_packer;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int CW = 3;
    localparam int W  = DW * R;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_read;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef PACK_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend[$];
    logic [W-1:0]  recv_data[$];
    logic [CW-1:0] recv_cnt[$];
    int            recv_cyc[$];
    int            pop_cyc[$];
    int            npops = 0;
    int            cyc = 0;

    fifo_word_packer #(.DATAWIDTH(DW), .RATIO(R), .CNTWIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_read  (fifo_read),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
`ifdef PACK_FLUSH_EN
        .flush      (flush),
`endif
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // FIFO model and output monitor; FIFO flags update via NBA so the DUT sees pre-edge values.
    always @(posedge clk) begin
        cyc++;
        if (fifo_read && fq.size() > 0) begin
            void'(fq.pop_front());
            pop_cyc.push_back(cyc);
            npops++;
        end
        while (pend.size() > 0) fq.push_back(pend.pop_front());
        fifo_dout  <= (fq.size() > 0) ? fq[0] : '0;
        fifo_empty <= (fq.size() == 0);
        if (out_valid && out_ready) begin
            recv_data.push_back(out_data);
            recv_cnt.push_back(out_count);
            recv_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        recv_data.delete();
        recv_cnt.delete();
        recv_cyc.delete();
        pop_cyc.delete();
        npops = 0;
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) pend.push_back(DW'(first + i));
    endtask

    task automatic wait_recv(input int n, input string name);
        int b;
        b = 0;
        while (recv_data.size() < n && b < 200) begin tick(1); b++; end
        if (recv_data.size() < n) begin
            total++;
            $display("FAIL %s timeout: words=%0d required=%0d", name, recv_data.size(), n);
        end
    endtask

    task automatic wait_pops(input int n, input string name);
        int b;
        b = 0;
        while (npops < n && b < 200) begin tick(1); b++; end
        if (npops < n) begin
            total++;
            $display("FAIL %s timeout: pops=%0d required=%0d", name, npops, n);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        tick(1);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL reset_data got=%h exp=0", out_data); else passed++;
        total++; if (out_count !== '0) $display("FAIL reset_count got=%0d exp=0", out_count); else passed++;
        total++; if (fifo_read !== 1'b0) $display("FAIL reset_read got=%b exp=0", fifo_read); else passed++;
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic_pack();
        clear_logs();
        out_ready = 1'b1;
        pend.push_back(8'h11); pend.push_back(8'h22); pend.push_back(8'h33); pend.push_back(8'h44);
        wait_recv(1, "basic");
        tick(5);
        total++; if (recv_data.size() !== 1) $display("FAIL basic_nwords got=%0d exp=1", recv_data.size()); else passed++;
        if (recv_data.size() > 0) begin
            total++; if (recv_data[0] !== 32'h44332211) $display("FAIL basic_data got=%h exp=44332211", recv_data[0]); else passed++;
            total++; if (recv_cnt[0] !== CW'(4)) $display("FAIL basic_count got=%0d exp=4", recv_cnt[0]); else passed++;
            // valid rises after the edge following the 4th pop, accepted on the edge after that
            total++; if (pop_cyc.size() != 4 || recv_cyc[0] - pop_cyc[3] != 2)
                $display("FAIL basic_latency got=%0d exp=2", recv_cyc[0] - pop_cyc[pop_cyc.size()-1]); else passed++;
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] exp [3];
        exp[0] = 32'h04030201; exp[1] = 32'h08070605; exp[2] = 32'h0C0B0A09;
        clear_logs();
        out_ready = 1'b1;
        push_range(1, 12);
        wait_recv(3, "stream");
        tick(5);
        total++; if (recv_data.size() !== 3) $display("FAIL stream_nwords got=%0d exp=3", recv_data.size()); else passed++;
        for (int i = 0; i < 3 && i < recv_data.size(); i++) begin
            total++; if (recv_data[i] !== exp[i]) $display("FAIL stream_word%0d got=%h exp=%h", i, recv_data[i], exp[i]); else passed++;
        end
        total++; if (pop_cyc.size() != 12 || pop_cyc[11] - pop_cyc[0] != 11)
            $display("FAIL stream_pop_gapless pops=%0d exp=12 contiguous", pop_cyc.size()); else passed++;
        if (recv_cyc.size() == 3) begin
            total++; if (recv_cyc[1] - recv_cyc[0] != 4 || recv_cyc[2] - recv_cyc[1] != 4)
                $display("FAIL stream_spacing got=%0d,%0d exp=4,4", recv_cyc[1] - recv_cyc[0], recv_cyc[2] - recv_cyc[1]); else passed++;
        end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] exp [3];
        exp[0] = 32'h04030201; exp[1] = 32'h08070605; exp[2] = 32'h0C0B0A09;
        clear_logs();
        out_ready = 1'b0;
        push_range(1, 12);
        tick(30);
        total++; if (npops !== 8) $display("FAIL bp_pops got=%0d exp=8", npops); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", out_valid); else passed++;
        total++; if (out_data !== 32'h04030201) $display("FAIL bp_hold got=%h exp=04030201", out_data); else passed++;
        total++; if (fifo_read !== 1'b0) $display("FAIL bp_read got=%b exp=0", fifo_read); else passed++;
        out_ready = 1'b1;
        wait_recv(3, "bp");
        tick(10);
        total++; if (recv_data.size() !== 3) $display("FAIL bp_nwords got=%0d exp=3", recv_data.size()); else passed++;
        for (int i = 0; i < 3 && i < recv_data.size(); i++) begin
            total++; if (recv_data[i] !== exp[i]) $display("FAIL bp_word%0d got=%h exp=%h", i, recv_data[i], exp[i]); else passed++;
        end
    endtask

    task automatic test_reset_midword();
        clear_logs();
        out_ready = 1'b1;
        pend.push_back(8'hAA); pend.push_back(8'hBB);
        wait_pops(2, "midword");
        tick(2);
        reset = 1'b1;
        #1;
        total++; if (fifo_read !== 1'b0) $display("FAIL midword_read_in_reset got=%b exp=0", fifo_read); else passed++;
        tick(2);
        reset = 1'b0;
        tick(1);
        push_range(1, 4);
        wait_recv(1, "midword");
        tick(10);
        total++; if (recv_data.size() !== 1) $display("FAIL midword_nwords got=%0d exp=1", recv_data.size()); else passed++;
        if (recv_data.size() > 0) begin
            total++; if (recv_data[0] !== 32'h04030201) $display("FAIL midword_data got=%h exp=04030201", recv_data[0]); else passed++;
            total++; if (recv_cnt[0] !== CW'(4)) $display("FAIL midword_count got=%0d exp=4", recv_cnt[0]); else passed++;
        end
    endtask

`ifdef PACK_FLUSH_EN
    task automatic test_flush();
        clear_logs();
        out_ready = 1'b1;
        pend.push_back(8'h5A); pend.push_back(8'h6B);
        wait_pops(2, "flush");
        tick(2);
        flush = 1'b1; tick(1); flush = 1'b0;
        wait_recv(1, "flush");
        tick(5);
        total++; if (recv_data.size() !== 1) $display("FAIL flush_nwords got=%0d exp=1", recv_data.size()); else passed++;
        if (recv_data.size() > 0) begin
            total++; if (recv_data[0] !== 32'h00006B5A) $display("FAIL flush_data got=%h exp=00006b5a", recv_data[0]); else passed++;
            total++; if (recv_cnt[0] !== CW'(2)) $display("FAIL flush_count got=%0d exp=2", recv_cnt[0]); else passed++;
        end
        clear_logs();
        flush = 1'b1; tick(1); flush = 1'b0;
        tick(10);
        total++; if (recv_data.size() !== 0) $display("FAIL flush_empty_nwords got=%0d exp=0", recv_data.size()); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_empty_valid got=%b exp=0", out_valid); else passed++;
        // pops resume once the empty flush retires
        push_range(1, 4);
        wait_recv(1, "flush_after");
        tick(2);
        total++; if (recv_data.size() != 1 || recv_data[0] !== 32'h04030201)
            $display("FAIL flush_after_data got=%h exp=04030201", (recv_data.size() > 0) ? recv_data[0] : '0); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_pack();
        test_streaming();
        test_back_pressure();
        test_reset_midword();
`ifdef PACK_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
